// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// Holds the FSM state enum, ALUControl codes, data-processing Cmd values,
// instruction Op classes, datapath mux-select codes and the condition-code
// evaluation helper used by the conditional-execution logic.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    // Data-processing Cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Instruction classes (Instr[27:26])
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // ALUSrcA selects
    localparam logic [1:0] SRCA_REG    = 2'b00;
    localparam logic [1:0] SRCA_ALUOUT = 2'b01;
    localparam logic [1:0] SRCA_PC     = 2'b10;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ResultSrc selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Evaluate an ARM condition field against flags {N,Z,C,V}; 1111 never executes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = ~(n ^ v);
            4'b1011: res = n ^ v;
            4'b1100: res = ~z & ~(n ^ v);
            4'b1101: res = z | (n ^ v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic: conditional-execution unit of the multicycle controller.
// Keeps the NZCV flags register and the CondEx result latched at the end of
// DECODE, and gates the FSM's raw write requests into the final enables.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   cond             Instr[31:28]
//   aluflags         {N,Z,C,V} from the ALU
//   flagw            {NZ write, CV write} requests from the decoder
//   decode_state     high in DECODE (CondExReg capture)
//   execute_state    high in EXECUTER/EXECUTEI (flag update window)
//   pcs, regw, memw, nextpc   raw requests from the FSM/decoder
//   pcwrite, regwrite, memwrite   gated enables (forced 0 during reset)
module mc_condlogic
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic [1:0] flagw,
    input  logic       decode_state,
    input  logic       execute_state,
    input  logic       pcs,
    input  logic       regw,
    input  logic       memw,
    input  logic       nextpc,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite
);

    logic [3:0] flags_r;
    logic       condexreg_r;
    logic       condex_s;

    assign condex_s = cond_eval(cond, flags_r);

    // Flags register and CondExReg; flags written here only become visible to later instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r     <= 4'b0000;
            condexreg_r <= 1'b0;
        end else begin
            if (decode_state) begin
                condexreg_r <= condex_s;
            end
            if (execute_state && condexreg_r) begin
                if (flagw[1]) begin
                    flags_r[3:2] <= aluflags[3:2];
                end
                if (flagw[0]) begin
                    flags_r[1:0] <= aluflags[1:0];
                end
            end
        end
    end

    // Final write gating; reset suppresses every architectural write strobe
    always_comb begin
        pcwrite  = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        if (reset) begin
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
        end else begin
            pcwrite  = nextpc | (pcs & condexreg_r);
            regwrite = regw & condexreg_r;
            memwrite = memw & condexreg_r;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: control unit for the multicycle single-memory ARM-subset CPU.
// Main FSM, instruction/ALU decoders and the conditional-execution unit.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   Instr          instruction register contents (bits [31:12] used)
//   ALUFlags       {N,Z,C,V} from the ALU
//   PCWrite, MemWrite, RegWrite, IRWrite   datapath write enables
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc   datapath selects
//   ALUControl     ALU operation
// All outputs are combinational from the current state and Instr.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] cmd_s;
    logic [3:0] rd_s;
    logic       irw_s;
    logic       nextpc_s;
    logic       regw_s;
    logic       memw_s;
    logic       branch_s;
    logic       aluop_s;
    logic       pcs_s;
    logic       is_cmp_s;
    logic       cv_cmd_s;
    logic [2:0] alu_cmd_s;
    logic [1:0] flagw_s;
    logic       unused_instr_bits_s;

    assign op_s    = Instr[27:26];
    assign funct_s = Instr[25:20];
    assign cmd_s   = funct_s[4:1];
    assign rd_s    = Instr[15:12];
    assign ImmSrc  = op_s;
    assign unused_instr_bits_s = ^{Instr[19:16], Instr[11:0]};

    // Register-file read port steering: branches read R15, stores read Rd as data
    assign RegSrc = {(op_s == OP_MEM), (op_s == OP_BR)};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: next_state_s = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_MEM:  next_state_s = S_MEMADR;
                    OP_DP:   next_state_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   next_state_s = S_BRANCH;
                    default: next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state_s = funct_s[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Moore outputs per state
    always_comb begin
        irw_s     = 1'b0;
        nextpc_s  = 1'b0;
        regw_s    = 1'b0;
        memw_s    = 1'b0;
        branch_s  = 1'b0;
        aluop_s   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_WD;
        ResultSrc = RES_ALUOUT;
        case (state_r)
            S_FETCH: begin
                irw_s     = 1'b1;
                nextpc_s  = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                regw_s    = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                memw_s = 1'b1;
            end
            S_EXECUTER: begin
                aluop_s = 1'b1;
            end
            S_EXECUTEI: begin
                ALUSrcB = SRCB_IMM;
                aluop_s = 1'b1;
            end
            S_ALUWB: begin
                regw_s = ~is_cmp_s;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch_s  = 1'b1;
            end
            default: begin
                irw_s = 1'b0;
            end
        endcase
    end

    // ALU decoder; unsupported commands fall back to ADD with a normal writeback
    always_comb begin
        alu_cmd_s = ALU_ADD;
        is_cmp_s  = 1'b0;
        cv_cmd_s  = 1'b0;
        case (cmd_s)
            CMD_ADD: begin
                alu_cmd_s = ALU_ADD;
                cv_cmd_s  = 1'b1;
            end
            CMD_SUB: begin
                alu_cmd_s = ALU_SUB;
                cv_cmd_s  = 1'b1;
            end
            CMD_AND: alu_cmd_s = ALU_AND;
            CMD_ORR: alu_cmd_s = ALU_ORR;
            CMD_EOR: alu_cmd_s = ALU_EOR;
            CMD_CMP: begin
                alu_cmd_s = ALU_SUB;
                is_cmp_s  = 1'b1;
                cv_cmd_s  = 1'b1;
            end
            default: alu_cmd_s = ALU_ADD;
        endcase
    end

    // ALUControl only follows the instruction in the execute states
    always_comb begin
        ALUControl = ALU_ADD;
        if (aluop_s) begin
            ALUControl = alu_cmd_s;
        end else begin
            ALUControl = ALU_ADD;
        end
    end

    // CMP always updates all four flags, regardless of its S bit
    assign flagw_s[1] = funct_s[0] | is_cmp_s;
    assign flagw_s[0] = is_cmp_s | (funct_s[0] & cv_cmd_s);

    // Writes to R15 are PC writes
    assign pcs_s   = branch_s | (regw_s & (rd_s == 4'd15));
    assign IRWrite = irw_s & ~reset;

    mc_condlogic u_condlogic (
        .clk           (clk),
        .reset         (reset),
        .cond          (Instr[31:28]),
        .aluflags      (ALUFlags),
        .flagw         (flagw_s),
        .decode_state  (state_r == S_DECODE),
        .execute_state ((state_r == S_EXECUTER) || (state_r == S_EXECUTEI)),
        .pcs           (pcs_s),
        .regw          (regw_s),
        .memw          (memw_s),
        .nextpc        (nextpc_s),
        .pcwrite       (PCWrite),
        .regwrite      (RegWrite),
        .memwrite      (MemWrite)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: directed instruction table, reset sequences
// and randomized instructions checked cycle-by-cycle against a behavioural
// model of the instruction timing and conditional-execution rules.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic [1:0] imm;
        logic [2:0] alu;
    } outv_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  af;
        logic        regw;
        logic        memw;
        logic        pcw;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] mflags;
    outv_t      expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic outv_t dut_out();
        outv_t o;
        o = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUControl};
        return o;
    endfunction

    function automatic outv_t blank(input logic [1:0] op);
        outv_t r;
        r = '0;
        r.imm = op;
        return r;
    endfunction

    // ARM condition: even codes test a predicate, the odd neighbour its inverse
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return cond[0] ? ~base : base;
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'd0;
            4'b0010: return 3'd1;
            4'b0000: return 3'd2;
            4'b1100: return 3'd3;
            4'b0001: return 3'd4;
            4'b1010: return 3'd1;
            default: return 3'd0;
        endcase
    endfunction

    // Expected per-cycle outputs for one instruction; also advances the model flags
    function automatic void build(input logic [31:0] ins, input logic [3:0] af);
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] cmd, rd;
        logic       ex, cmp, s;
        outv_t      r;
        op = ins[27:26]; funct = ins[25:20]; cmd = funct[4:1]; rd = ins[15:12];
        s = funct[0];
        ex = cond_holds(ins[31:28], mflags);
        expq.delete();
        r = blank(op); r.pcw = 1'b1; r.irw = 1'b1; r.srca = 2'd2; r.srcb = 2'd2; r.res = 2'd2;
        expq.push_back(r);
        r = blank(op); r.srca = 2'd2; r.srcb = 2'd2; r.res = 2'd2;
        expq.push_back(r);
        case (op)
            2'b01: begin
                r = blank(op); r.srcb = 2'd1; expq.push_back(r);
                if (funct[0]) begin
                    r = blank(op); r.adr = 1'b1; expq.push_back(r);
                    r = blank(op); r.res = 2'd1; r.regw = ex; r.pcw = ex && (rd == 4'd15);
                    expq.push_back(r);
                end else begin
                    r = blank(op); r.adr = 1'b1; r.memw = ex; expq.push_back(r);
                end
            end
            2'b00: begin
                cmp = (cmd == 4'b1010);
                r = blank(op); r.srcb = funct[5] ? 2'd1 : 2'd0; r.alu = alu_of(cmd);
                expq.push_back(r);
                r = blank(op); r.regw = ex && !cmp; r.pcw = ex && !cmp && (rd == 4'd15);
                expq.push_back(r);
                if (ex) begin
                    if (s || cmp) mflags[3:2] = af[3:2];
                    if (cmp || (s && (cmd == 4'b0100 || cmd == 4'b0010))) mflags[1:0] = af[1:0];
                end
            end
            2'b10: begin
                r = blank(op); r.srcb = 2'd1; r.res = 2'd2; r.pcw = ex; expq.push_back(r);
            end
            default: ;
        endcase
    endfunction

    // Start of a FETCH cycle: run one instruction and compare every cycle
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             output logic any_regw, output logic any_memw, output logic any_pcw);
        outv_t act;
        Instr = ins;
        ALUFlags = af;
        build(ins, af);
        any_regw = 1'b0; any_memw = 1'b0; any_pcw = 1'b0;
        #1;
        for (int k = 0; k < expq.size(); k++) begin
            act = dut_out();
            check($sformatf("cyc%0d_%08h", k, ins), 32'(act), 32'(expq[k]));
            if (k > 0) begin
                any_regw |= RegWrite;
                any_memw |= MemWrite;
                any_pcw  |= PCWrite;
            end
            @(posedge clk);
            #1;
        end
        check($sformatf("next_fetch_%08h", ins), 32'(IRWrite), 32'd1);
    endtask

    vec_t  tbl[14];
    outv_t rst_exp;
    logic  rw, mw, pw;
    logic [31:0] rins;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'hE0821003, 4'b0000, 1'b1, 1'b0, 1'b0}; // ADD R1,R2,R3
        tbl[1]  = '{32'hE5910004, 4'b0000, 1'b1, 1'b0, 1'b0}; // LDR
        tbl[2]  = '{32'hE5810004, 4'b0000, 1'b0, 1'b1, 1'b0}; // STR
        tbl[3]  = '{32'hE2511001, 4'b0100, 1'b1, 1'b0, 1'b0}; // SUBS -> Z=1
        tbl[4]  = '{32'h0A000002, 4'b0000, 1'b0, 1'b0, 1'b1}; // BEQ taken
        tbl[5]  = '{32'hE1510002, 4'b0000, 1'b0, 1'b0, 1'b0}; // CMP -> flags 0000
        tbl[6]  = '{32'h0A000002, 4'b0000, 1'b0, 1'b0, 1'b0}; // BEQ not taken
        tbl[7]  = '{32'hE28FF008, 4'b0000, 1'b1, 1'b0, 1'b1}; // ADD PC,PC,#8
        tbl[8]  = '{32'hE1510002, 4'b0100, 1'b0, 1'b0, 1'b0}; // CMP -> Z=1
        tbl[9]  = '{32'h129FF008, 4'b1011, 1'b0, 1'b0, 1'b0}; // ADDSNE PC: suppressed
        tbl[10] = '{32'h0A000002, 4'b0000, 1'b0, 1'b0, 1'b1}; // BEQ: Z still set
        tbl[11] = '{32'hEC000000, 4'b0000, 1'b0, 1'b0, 1'b0}; // Op 11
        tbl[12] = '{32'hE1A01002, 4'b0000, 1'b1, 1'b0, 1'b0}; // unsupported Cmd
        tbl[13] = '{32'hF0821003, 4'b0000, 1'b0, 1'b0, 1'b0}; // cond 1111

        // Reset held two cycles: enables low, FETCH selects visible
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0; mflags = 4'h0;
        rst_exp = blank(2'b00); rst_exp.srca = 2'd2; rst_exp.srcb = 2'd2; rst_exp.res = 2'd2;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_cyc%0d", c), 32'(dut_out()), 32'(rst_exp));
        end
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].ins, tbl[i].af, rw, mw, pw);
            check($sformatf("tbl%0d_regwrite", i), 32'(rw), 32'(tbl[i].regw));
            check($sformatf("tbl%0d_memwrite", i), 32'(mw), 32'(tbl[i].memw));
            check($sformatf("tbl%0d_pcwrite", i), 32'(pw), 32'(tbl[i].pcw));
        end

        // Reset during MEMWRITE of a store: strobe suppressed, back to FETCH
        Instr = 32'hE5810004; ALUFlags = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("midrst_enables", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
        @(posedge clk);
        #1;
        rst_exp = blank(2'b01); rst_exp.srca = 2'd2; rst_exp.srcb = 2'd2; rst_exp.res = 2'd2;
        check("midrst_fetch_held", 32'(dut_out()), 32'(rst_exp));
        reset = 1'b0;
        mflags = 4'h0;
        #1;
        rst_exp.pcw = 1'b1; rst_exp.irw = 1'b1;
        check("midrst_first_fetch", 32'(dut_out()), 32'(rst_exp));

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            rins[31:28] = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
            rins[27:26] = 2'($urandom_range(0, 3));
            rins[25:20] = 6'($urandom);
            rins[19:16] = 4'($urandom);
            rins[15:12] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
            rins[11:0]  = 12'($urandom);
            run_instr(rins, 4'($urandom), rw, mw, pw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
